// File: rtl/video_ctrl_pkg.sv
// Shared op codes, colour-mode codes, FSM states and op-classification helpers
// for the video control sequencer.
package video_ctrl_pkg;

  localparam logic [7:0] OP_NOP        = 8'd0;
  localparam logic [7:0] OP_COLORMODE  = 8'd1;
  localparam logic [7:0] OP_DIMENSIONS = 8'd2;
  localparam logic [7:0] OP_PALETTE    = 8'd3;
  localparam logic [7:0] OP_SCALE      = 8'd4;
  localparam logic [7:0] OP_VSYNC      = 8'd5;

  typedef enum logic [31:0] {
    CMODE_INDEXED8 = 32'd0,
    CMODE_RGB565   = 32'd1,
    CMODE_RGB888   = 32'd2,
    CMODE_ARGB8888 = 32'd4
  } color_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_FLUSH
  } state_t;

  function automatic logic is_immediate(input logic [7:0] op);
    return (op == OP_PALETTE) || (op == OP_VSYNC);
  endfunction

  function automatic logic is_deferred(input logic [7:0] op);
    return (op == OP_COLORMODE) || (op == OP_DIMENSIONS) || (op == OP_SCALE);
  endfunction

  // Shadow slot index doubles as flush priority: lower slot issues first.
  function automatic logic [1:0] shadow_slot(input logic [7:0] op);
    case (op)
      OP_DIMENSIONS: return 2'd1;
      OP_SCALE:      return 2'd2;
      default:       return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] slot_op(input logic [1:0] slot);
    case (slot)
      2'd1:    return OP_DIMENSIONS;
      2'd2:    return OP_SCALE;
      default: return OP_COLORMODE;
    endcase
  endfunction

endpackage

// File: rtl/vctl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when the grant is consumed.
module vctl_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic grant0,
  output logic grant1
);

  // Remembers whether requester 1 won last; reset value favours requester 0.
  logic last1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last1 <= 1'b1;
    end else if (advance) begin
      last1 <= grant1;
    end
  end

  assign grant0 = valid0 && (!valid1 || last1);
  assign grant1 = valid1 && !grant0;

endmodule

// File: rtl/video_control_sequencer.sv
// Merges host and palette-engine command streams onto the video command bus,
// holding mode/geometry/scale writes in shadows until the next frame boundary.
module video_control_sequencer
  import video_ctrl_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic        m_axis_vid_aclk,
  input  logic        aresetn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_op,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_op,
  input  logic [31:0] req1_data,
  input  logic        frame_start,
  output logic [7:0]  control_op,
  output logic [31:0] control_data,
  output logic        busy,
  output logic        shadow_pending,
  output logic [7:0]  drop_cnt
);

  localparam logic [1:0] GAP_FULL = 2'(GAP_CYCLES);
  localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);

  state_t           state, state_next;
  logic [1:0]       gap_cnt, gap_cnt_next;
  logic [7:0]       control_op_next;
  logic [31:0]      control_data_next;
  logic [2:0]       shadow_valid, shadow_valid_next;
  logic [2:0][31:0] shadow_data;
  logic             flush_req, flush_next, flush_done;
  logic             ready_en, ready_en_next;
  logic             drop_inc, shadow_wr;
  logic             grant0, grant1, accept;
  logic [7:0]       sel_op;
  logic [31:0]      sel_data;
  logic [1:0]       sel_slot, flush_slot;
  logic             flush_hit;

  vctl_rr_arb2 u_arb (
    .clk     (m_axis_vid_aclk),
    .rst_n   (aresetn),
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .advance (accept),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  // ready_en is registered; the grant mask only keeps the loser from handshaking.
  assign req0_ready = ready_en && !grant1;
  assign req1_ready = ready_en && !grant0;
  assign accept     = ready_en && (grant0 || grant1);
  assign sel_op     = grant1 ? req1_op   : req0_op;
  assign sel_data   = grant1 ? req1_data : req0_data;
  assign sel_slot   = shadow_slot(sel_op);
  assign flush_hit  = |shadow_valid;
  assign flush_slot = shadow_valid[0] ? 2'd0 : (shadow_valid[1] ? 2'd1 : 2'd2);

  always_comb begin
    state_next        = state;
    gap_cnt_next      = gap_cnt;
    control_op_next   = OP_NOP;
    control_data_next = '0;
    shadow_valid_next = shadow_valid;
    shadow_wr         = 1'b0;
    drop_inc          = 1'b0;
    flush_done        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flush_req) begin
          if (flush_hit) begin
            control_op_next               = slot_op(flush_slot);
            control_data_next             = shadow_data[flush_slot];
            shadow_valid_next[flush_slot] = 1'b0;
            gap_cnt_next                  = GAP_FULL;
            state_next                    = ST_FLUSH;
          end else begin
            flush_done = 1'b1;
          end
        end else if (accept) begin
          if (is_immediate(sel_op)) begin
            control_op_next   = sel_op;
            control_data_next = sel_data;
            state_next        = ST_ISSUE;
          end else if (is_deferred(sel_op)) begin
            shadow_valid_next[sel_slot] = 1'b1;
            shadow_wr                   = 1'b1;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        gap_cnt_next = GAP_LAST;
        state_next   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == 2'd0) state_next = ST_IDLE;
        else                 gap_cnt_next = gap_cnt - 2'd1;
      end
      ST_FLUSH: begin
        // gap_cnt counts down the NOPs trailing the command just issued.
        if (gap_cnt != 2'd0) begin
          gap_cnt_next = gap_cnt - 2'd1;
        end else if (flush_hit) begin
          control_op_next               = slot_op(flush_slot);
          control_data_next             = shadow_data[flush_slot];
          shadow_valid_next[flush_slot] = 1'b0;
          gap_cnt_next                  = GAP_FULL;
        end else begin
          flush_done = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Using the post-write shadow state lets a same-cycle deferred write join the flush.
    flush_next    = (flush_req && !flush_done) || (frame_start && (|shadow_valid_next));
    ready_en_next = (state_next == ST_IDLE) && !flush_next;
  end

  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= ST_IDLE;
      gap_cnt        <= '0;
      control_op     <= OP_NOP;
      control_data   <= '0;
      shadow_valid   <= '0;
      shadow_data    <= '0;
      flush_req      <= 1'b0;
      ready_en       <= 1'b0;
      busy           <= 1'b0;
      shadow_pending <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      state          <= state_next;
      gap_cnt        <= gap_cnt_next;
      control_op     <= control_op_next;
      control_data   <= control_data_next;
      shadow_valid   <= shadow_valid_next;
      flush_req      <= flush_next;
      ready_en       <= ready_en_next;
      busy           <= (state_next != ST_IDLE);
      shadow_pending <= |shadow_valid_next;
      if (shadow_wr) shadow_data[sel_slot] <= sel_data;
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: doc/video_control_sequencer.md
VIDEO_CONTROL_SEQUENCER -- requirements
Module: video_control_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 1, meaning the number of NOP cycles inserted after every issued command (range 1..3).
REQ-002 SHALL have ports: m_axis_vid_aclk  in  1  sole clock; aresetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req0_valid in 1, req0_ready out 1, req0_op in 8, req0_data in 32  host register-write requester.
REQ-004 SHALL have ports: req1_valid in 1, req1_ready out 1, req1_op in 8, req1_data in 32  palette-load engine requester.
REQ-005 SHALL have port frame_start  in  1  one-cycle strobe at output frame boundary.
REQ-006 SHALL have ports: control_op out 8, control_data out 32  command bus to the video output block; op 0 means NOP.
REQ-007 SHALL have ports: busy out 1 (state not IDLE), shadow_pending out 1 (any shadow valid), drop_cnt out 8 (dropped illegal ops).

Function
REQ-008 SHALL classify ops: PALETTE(3) and VSYNC(5) immediate; COLORMODE(1), DIMENSIONS(2) and SCALE(4) deferred; every other value illegal.
REQ-009 SHALL implement FSM states IDLE, ISSUE, GAP and FLUSH.
REQ-010 SHALL assert reqN_ready only in IDLE with no flush latched; a handshake is valid&&ready on the same cycle.
REQ-011 SHALL arbitrate round-robin when both requesters are valid: grant the one not granted last; the pointer updates only on an accepted handshake.
REQ-012 SHALL handle an accepted immediate op at cycle t by registering it: control_op/control_data carry it for exactly cycle t+1 (ISSUE), then GAP_CYCLES NOP cycles, then IDLE.
REQ-013 SHALL handle an accepted deferred op by writing data into its shadow register and setting its valid flag, staying in IDLE with no bus activity; a later write to a valid shadow overwrites it (latest wins).
REQ-014 SHALL handle an illegal op by accepting and discarding it, with drop_cnt incrementing and saturating at 255.
REQ-015 SHALL, on frame_start with shadow_pending=1, latch flush_req; frame_start in any state is latched, and frame_start with no shadow valid is ignored.
REQ-016 SHALL give flush_req priority over requesters in IDLE: enter FLUSH, issue the valid shadows in order COLORMODE, DIMENSIONS, SCALE, each for one cycle followed by GAP_CYCLES NOPs, clear each flag on issue, then clear flush_req and return to IDLE.
REQ-017 SHALL, on simultaneous accept of a deferred op and frame_start in IDLE, include that op in the triggered flush.
REQ-018 SHALL drive control_op=0 and control_data=0 on every cycle not carrying a command.
REQ-019 SHALL register all outputs; no combinational path exists from inputs to control_op/control_data.

Reset
REQ-020 SHALL, on aresetn low, immediately force state IDLE, control_op=0, control_data=0, readys 0, busy 0, all shadow flags and flush_req clear, drop_cnt 0, RR pointer favouring req0; readys rise on the first clock after deassertion.
REQ-021 SHALL, on reset mid-ISSUE or mid-FLUSH, abandon the command and lose the shadow contents.

Structure
REQ-022 SHALL place op codes (1..5), colour-mode codes (0,1,2,4), and the FSM state enum in shared package video_ctrl_pkg.
REQ-023 SHALL place round-robin two-way arbitration in sub-module vctl_rr_arb2 (inputs valid0/valid1/advance, outputs grant0/grant1).

Verification
REQ-024 SHALL verify: req1 PALETTE data 0x05FF8000 accepted at t -> control_op=3, data=0x05FF8000 at t+1 only; NOP at t+2; req1_ready high again at t+3 (GAP_CYCLES=1).
REQ-025 SHALL verify: req0 DIMENSIONS 0x01E00280, then 0x02D00500 before frame_start -> no bus activity; after frame_start, one op 2 with 0x02D00500.
REQ-026 SHALL verify: COLORMODE 2, SCALE 3 and DIMENSIONS queued, then frame_start -> bus order op1/2, op2, op4/3 with one NOP between each; shadow_pending=0 afterward.
REQ-027 SHALL verify: both requesters valid continuously with PALETTE ops -> grants alternate 0,1,0,1; no starvation across 8 commands.
REQ-028 SHALL verify: op 7 and op 0 accepted -> no bus activity; drop_cnt=2; 300 illegal ops -> drop_cnt=255.
REQ-029 SHALL verify: aresetn asserted during FLUSH after COLORMODE issued -> control_op=0 asynchronously; after release, shadow_pending=0 and no further ops issue.
